pulse_tx_framer: RTL and testbench

//  Transmit-side framer for the pulse link; peer of the phase-search receiver.

---
 rtl/pulse_link_pkg.sv | 23 ++
 rtl/pulse_bit_timer.sv | 42 ++++
 rtl/pulse_tx_framer.sv | 176 +++++++++++++++++
 tb/tb_pulse_tx_framer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_link_pkg.sv
// Shared definitions for the pulse link transmitter and receiver:
// FSM encoding, divider floor and the pulse-width rule both ends must agree on.
package pulse_link_pkg;

    localparam int unsigned DIV_W = 8;
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } link_state_t;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

    // Gate width used by the receiver as well; never shorter than one cycle.
    function automatic logic [DIV_W-1:0] pulse_width(input logic [DIV_W-1:0] div);
        return ((div >> 1) == '0) ? DIV_W'(1) : (div >> 1);
    endfunction

endpackage

// File: rtl/pulse_bit_timer.sv
// Bit-period timer: latches the divider at frame start and reports period end
// plus whether the next cycle lies inside the pulse window.
module pulse_bit_timer
    import pulse_link_pkg::*;
(
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             period_end_c,
    output logic             in_pulse_c
);

    logic [DIV_W-1:0] dr_l;
    logic [DIV_W-1:0] pw_l;
    logic [DIV_W-1:0] bit_cnt;
    logic [DIV_W-1:0] cnt_next_c;

    assign period_end_c = run && (bit_cnt == (dr_l - DIV_W'(1)));
    assign cnt_next_c   = period_end_c ? '0 : (bit_cnt + DIV_W'(1));

    // A load restarts the count at 0, which is always inside the window.
    assign in_pulse_c   = load || (cnt_next_c < pw_l);

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            dr_l    <= '0;
            pw_l    <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            dr_l    <= clamp_div(div_ratio);
            pw_l    <= pulse_width(clamp_div(div_ratio));
            bit_cnt <= '0;
        end else if (!run) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= cnt_next_c;
        end
    end

endmodule

// File: rtl/pulse_tx_framer.sv
// Transmit framer for the pulse link: all-ones preamble then OOK payload, MSB first,
// with a one-byte holding buffer fed over a valid/ready stream.
module pulse_tx_framer
    import pulse_link_pkg::*;
#(
    parameter int unsigned PREAMBLE_BITS = 32,
    parameter int unsigned LEN_W         = 8
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             enable,
    input  logic [7:0]       div_ratio,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_pulse,
    output logic             preamble_end,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int unsigned PRE_W = $clog2(PREAMBLE_BITS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_BITS - 1);

    link_state_t      state;
    logic [7:0]       shift_q;
    logic [7:0]       hold_q;
    logic             hold_full;
    logic [2:0]       bit_idx;
    logic [PRE_W-1:0] pre_cnt;
    logic [LEN_W-1:0] len_l;
    logic [LEN_W-1:0] byte_cnt;
    logic [LEN_W-1:0] taken;

    logic accept_c;
    logic take_c;
    logic run_c;
    logic period_end_c;
    logic in_pulse_c;

    assign busy     = (state != ST_IDLE);
    assign tx_ready = busy && !hold_full && (taken < len_l);
    assign take_c   = tx_valid && tx_ready;
    // A start coinciding with the done pulse must not chain frames.
    assign accept_c = (state == ST_IDLE) && enable && start && !done;
    assign run_c    = busy && enable;

    pulse_bit_timer u_timer (
        .clk_fast     (clk_fast),
        .rst          (rst),
        .load         (accept_c),
        .run          (run_c),
        .div_ratio    (div_ratio),
        .period_end_c (period_end_c),
        .in_pulse_c   (in_pulse_c)
    );

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            tx_pulse     <= 1'b0;
            preamble_end <= 1'b0;
            done         <= 1'b0;
            underrun     <= 1'b0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full    <= 1'b0;
            bit_idx      <= '0;
            pre_cnt      <= '0;
            len_l        <= '0;
            byte_cnt     <= '0;
            taken        <= '0;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            if (take_c) begin
                hold_q    <= tx_data;
                hold_full <= 1'b1;
                taken     <= taken + LEN_W'(1);
            end
            unique case (state)
                ST_IDLE: begin
                    tx_pulse     <= 1'b0;
                    preamble_end <= 1'b0;
                    if (accept_c) begin
                        state     <= ST_PREAMBLE;
                        len_l     <= frame_len;
                        pre_cnt   <= '0;
                        byte_cnt  <= '0;
                        taken     <= '0;
                        hold_full <= 1'b0;
                        tx_pulse  <= 1'b1;
                    end
                end
                ST_PREAMBLE: begin
                    if (!enable) begin
                        state        <= ST_IDLE;
                        tx_pulse     <= 1'b0;
                        preamble_end <= 1'b0;
                        hold_full    <= 1'b0;
                    end else if (period_end_c && (pre_cnt == PRE_LAST)) begin
                        if (len_l == '0) begin
                            state    <= ST_IDLE;
                            tx_pulse <= 1'b0;
                            done     <= 1'b1;
                        end else if (!hold_full) begin
                            state        <= ST_IDLE;
                            tx_pulse     <= 1'b0;
                            preamble_end <= 1'b0;
                            hold_full    <= 1'b0;
                            underrun     <= 1'b1;
                        end else begin
                            state        <= ST_DATA;
                            shift_q      <= hold_q;
                            hold_full    <= take_c;
                            byte_cnt     <= byte_cnt + LEN_W'(1);
                            bit_idx      <= '0;
                            preamble_end <= 1'b1;
                            tx_pulse     <= hold_q[7] & in_pulse_c;
                        end
                    end else begin
                        if (period_end_c) begin
                            pre_cnt <= pre_cnt + PRE_W'(1);
                        end
                        tx_pulse <= in_pulse_c;
                    end
                end
                ST_DATA: begin
                    if (!enable) begin
                        state        <= ST_IDLE;
                        tx_pulse     <= 1'b0;
                        preamble_end <= 1'b0;
                        hold_full    <= 1'b0;
                    end else if (period_end_c && (bit_idx == 3'd7)) begin
                        // Byte boundary: finish, starve, or reload from the holding buffer.
                        if (byte_cnt == len_l) begin
                            state        <= ST_IDLE;
                            tx_pulse     <= 1'b0;
                            preamble_end <= 1'b0;
                            hold_full    <= 1'b0;
                            done         <= 1'b1;
                        end else if (!hold_full) begin
                            state        <= ST_IDLE;
                            tx_pulse     <= 1'b0;
                            preamble_end <= 1'b0;
                            hold_full    <= 1'b0;
                            underrun     <= 1'b1;
                        end else begin
                            shift_q   <= hold_q;
                            hold_full <= take_c;
                            byte_cnt  <= byte_cnt + LEN_W'(1);
                            bit_idx   <= '0;
                            tx_pulse  <= hold_q[7] & in_pulse_c;
                        end
                    end else if (period_end_c) begin
                        shift_q  <= {shift_q[6:0], 1'b0};
                        bit_idx  <= bit_idx + 3'd1;
                        tx_pulse <= shift_q[6] & in_pulse_c;
                    end else begin
                        tx_pulse <= shift_q[7] & in_pulse_c;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    tx_pulse     <= 1'b0;
                    preamble_end <= 1'b0;
                    hold_full    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_tx_framer.sv
// Bench for pulse_tx_framer: byte feeder, line receiver model and per-scenario tasks
// comparing captured timing and recovered bytes against a scoreboard.
module tb_pulse_tx_framer;

    localparam int unsigned PB = 4;
    localparam int unsigned LW = 8;

    logic          clk_fast = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic [7:0]    div_ratio = 8'd8;
    logic          start = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx_pulse;
    logic          preamble_end;
    logic          busy;
    logic          done;
    logic          underrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    bit         high_at[int];
    int         pe_rise_q[$];
    int         done_q[$];
    int         ur_q[$];

    int         rx_dr = 2;
    int         rx_pw = 1;
    int         rx_phase = 0;
    int         rx_nbits = 0;
    int         shape_err = 0;
    logic       rx_bit = 1'b0;
    logic [7:0] rx_sh = 8'h00;
    logic       pe_prev = 1'b0;

    pulse_tx_framer #(
        .PREAMBLE_BITS (PB),
        .LEN_W         (LW)
    ) dut (
        .clk_fast     (clk_fast),
        .rst          (rst),
        .enable       (enable),
        .div_ratio    (div_ratio),
        .start        (start),
        .frame_len    (frame_len),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_pulse     (tx_pulse),
        .preamble_end (preamble_end),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun)
    );

    always #5 clk_fast = ~clk_fast;

    always @(posedge clk_fast) cyc <= cyc + 1;

    // Feeder, event capture and receiver model, all on the falling edge.
    always @(negedge clk_fast) begin
        tx_valid = (src_q.size() > 0);
        tx_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        if (tx_valid && tx_ready) exp_q.push_back(src_q.pop_front());
        if (tx_pulse) high_at[cyc] = 1'b1;
        if (done) done_q.push_back(cyc);
        if (underrun) ur_q.push_back(cyc);
        if (preamble_end && !pe_prev) begin
            pe_rise_q.push_back(cyc);
            rx_phase = 0;
            rx_nbits = 0;
        end
        if (preamble_end) begin
            if (rx_phase == 0) begin
                rx_bit = tx_pulse;
                rx_sh  = {rx_sh[6:0], tx_pulse};
                rx_nbits++;
                if (rx_nbits == 8) begin
                    rx_q.push_back(rx_sh);
                    rx_nbits = 0;
                end
            end else if (tx_pulse !== (rx_bit && (rx_phase < rx_pw))) begin
                shape_err++;
            end
            rx_phase = (rx_phase + 1 >= rx_dr) ? 0 : rx_phase + 1;
        end
        pe_prev = preamble_end;
    end

    task automatic tick();
        @(negedge clk_fast);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic clear_sb();
        src_q.delete();
        exp_q.delete();
        rx_q.delete();
        high_at.delete();
        pe_rise_q.delete();
        done_q.delete();
        ur_q.delete();
        shape_err = 0;
    endtask

    task automatic set_rx(input int div);
        rx_dr = (div < 2) ? 2 : div;
        rx_pw = (rx_dr / 2 < 1) ? 1 : rx_dr / 2;
    endtask

    task automatic start_frame(input logic [7:0] div, input logic [LW-1:0] len, output int t);
        tick();
        div_ratio = div;
        frame_len = len;
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [7:0] period_pat(input int s, input int dr);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < dr && k < 8; k++) p[k] = (high_at.exists(s + k) != 0);
        return p;
    endfunction

    function automatic int first_or_neg(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    task automatic test_reset();
        #2 rst = 1'b1;
        enable = 1'b0;
        repeat (3) tick();
        checks++; if (tx_pulse !== 1'b0) begin errors++; $display("FAIL reset_tx_pulse: got %b expected 0", tx_pulse); end
        checks++; if (preamble_end !== 1'b0) begin errors++; $display("FAIL reset_preamble_end: got %b expected 0", preamble_end); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0 || underrun !== 1'b0) begin errors++; $display("FAIL reset_strobes: got done=%b underrun=%b expected 0/0", done, underrun); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); end
        rst = 1'b0;
        enable = 1'b1;
        repeat (2) tick();
        checks++; if (busy !== 1'b0 || tx_pulse !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b tx_pulse=%b expected 0/0", busy, tx_pulse); end
    endtask

    task automatic test_basic_frame();
        int t;
        logic [7:0] e;
        logic [7:0] b;
        logic [7:0] a;
        logic [7:0] x;
        clear_sb();
        set_rx(8);
        src_q.push_back(8'hA5);
        start_frame(8'd8, 8'd1, t);
        wait_until(t + 97);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_cycle: got done=%b busy=%b expected 1/0", done, busy); end
        wait_until(t + 100);
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (period_pat(t + 1 + 8 * p, 8) !== 8'h0F) begin errors++; $display("FAIL basic_preamble_%0d: got %b expected 00001111", p, period_pat(t + 1 + 8 * p, 8)); end
        end
        b = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            e = b[7 - i] ? 8'h0F : 8'h00;
            checks++;
            if (period_pat(t + 33 + 8 * i, 8) !== e) begin errors++; $display("FAIL basic_bit_%0d: got %b expected %b", i, period_pat(t + 33 + 8 * i, 8), e); end
        end
        checks++; if (pe_rise_q.size() != 1 || first_or_neg(pe_rise_q) != t + 33) begin errors++; $display("FAIL basic_preamble_end: got rise at %0d expected %0d", first_or_neg(pe_rise_q) - t, 33); end
        checks++; if (done_q.size() != 1 || first_or_neg(done_q) != t + 97) begin errors++; $display("FAIL basic_done: got %0d pulses at +%0d expected 1 at +97", done_q.size(), first_or_neg(done_q) - t); end
        checks++; if (ur_q.size() != 0) begin errors++; $display("FAIL basic_underrun: got %0d expected 0", ur_q.size()); end
        checks++; if (shape_err != 0) begin errors++; $display("FAIL basic_shape: got %0d bad cycles expected 0", shape_err); end
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_rx_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            a = rx_q.pop_front();
            x = exp_q.pop_front();
            checks++; if (a !== x) begin errors++; $display("FAIL basic_rx_byte: got %h expected %h", a, x); end
        end
    endtask

    task automatic test_clamp_empty();
        int t;
        clear_sb();
        set_rx(1);
        start_frame(8'd1, 8'd0, t);
        wait_until(t + 9);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL clamp_done_cycle: got done=%b busy=%b expected 1/0", done, busy); end
        wait_until(t + 14);
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (period_pat(t + 1 + 2 * p, 2) !== 8'h01) begin errors++; $display("FAIL clamp_pulse_%0d: got %b expected 00000001", p, period_pat(t + 1 + 2 * p, 2)); end
        end
        checks++; if (high_at.num() != 4) begin errors++; $display("FAIL clamp_pulse_count: got %0d high cycles expected 4", high_at.num()); end
        checks++; if (pe_rise_q.size() != 0) begin errors++; $display("FAIL clamp_preamble_end: got %0d rises expected 0", pe_rise_q.size()); end
        checks++; if (done_q.size() != 1 || first_or_neg(done_q) != t + 9) begin errors++; $display("FAIL clamp_done: got %0d pulses at +%0d expected 1 at +9", done_q.size(), first_or_neg(done_q) - t); end
    endtask

    task automatic test_underrun();
        int t;
        logic [7:0] a;
        logic [7:0] x;
        clear_sb();
        set_rx(8);
        src_q.push_back(8'h3C);
        start_frame(8'd8, 8'd3, t);
        wait_until(t + 96);
        checks++; if (preamble_end !== 1'b1 || underrun !== 1'b0) begin errors++; $display("FAIL underrun_before: got pe=%b underrun=%b expected 1/0", preamble_end, underrun); end
        wait_until(t + 97);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_pulse: got %b expected 1", underrun); end
        checks++; if (busy !== 1'b0 || tx_pulse !== 1'b0 || preamble_end !== 1'b0) begin errors++; $display("FAIL underrun_outputs: got busy=%b pulse=%b pe=%b expected 0/0/0", busy, tx_pulse, preamble_end); end
        wait_until(t + 110);
        checks++; if (ur_q.size() != 1 || first_or_neg(ur_q) != t + 97) begin errors++; $display("FAIL underrun_cycle: got %0d pulses at +%0d expected 1 at +97", ur_q.size(), first_or_neg(ur_q) - t); end
        checks++; if (done_q.size() != 0) begin errors++; $display("FAIL underrun_no_done: got %0d expected 0", done_q.size()); end
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL underrun_rx_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            a = rx_q.pop_front();
            x = exp_q.pop_front();
            checks++; if (a !== x) begin errors++; $display("FAIL underrun_rx_byte: got %h expected %h", a, x); end
        end
    endtask

    task automatic test_enable_abort();
        int t;
        int hits;
        logic [7:0] a;
        logic [7:0] x;
        clear_sb();
        set_rx(8);
        src_q.push_back(8'hFF);
        src_q.push_back(8'h81);
        start_frame(8'd8, 8'd2, t);
        wait_until(t + 40);
        checks++; if (preamble_end !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL abort_in_data: got pe=%b busy=%b expected 1/1", preamble_end, busy); end
        enable = 1'b0;
        wait_until(t + 41);
        checks++; if (tx_pulse !== 1'b0 || preamble_end !== 1'b0) begin errors++; $display("FAIL abort_line: got pulse=%b pe=%b expected 0/0", tx_pulse, preamble_end); end
        checks++; if (busy !== 1'b0 || tx_ready !== 1'b0) begin errors++; $display("FAIL abort_busy: got busy=%b ready=%b expected 0/0", busy, tx_ready); end
        wait_until(t + 60);
        hits = 0;
        for (int c = t + 41; c <= t + 60; c++) if (high_at.exists(c)) hits++;
        checks++; if (hits != 0) begin errors++; $display("FAIL abort_quiet: got %0d high cycles expected 0", hits); end
        checks++; if (done_q.size() != 0 || ur_q.size() != 0) begin errors++; $display("FAIL abort_strobes: got done=%0d underrun=%0d expected 0/0", done_q.size(), ur_q.size()); end
        enable = 1'b1;
        clear_sb();
        set_rx(4);
        src_q.push_back(8'h5A);
        start_frame(8'd4, 8'd1, t);
        wait_until(t + 52);
        checks++; if (pe_rise_q.size() != 1 || first_or_neg(pe_rise_q) != t + 17) begin errors++; $display("FAIL restart_preamble_end: got rise at +%0d expected +17", first_or_neg(pe_rise_q) - t); end
        checks++; if (done_q.size() != 1 || first_or_neg(done_q) != t + 49) begin errors++; $display("FAIL restart_done: got %0d pulses at +%0d expected 1 at +49", done_q.size(), first_or_neg(done_q) - t); end
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL restart_rx_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            a = rx_q.pop_front();
            x = exp_q.pop_front();
            checks++; if (a !== x) begin errors++; $display("FAIL restart_rx_byte: got %h expected %h", a, x); end
        end
    endtask

    task automatic test_start_ignored();
        int t;
        logic [7:0] a;
        logic [7:0] x;
        clear_sb();
        set_rx(4);
        src_q.push_back(8'hC3);
        start_frame(8'd4, 8'd1, t);
        wait_until(t + 10);
        div_ratio = 8'd2;
        frame_len = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_until(t + 49);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_start_done: got %b expected 1", done); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_with_done: got busy=%b expected 0", busy); end
        wait_until(t + 56);
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (period_pat(t + 1 + 4 * p, 4) !== 8'h03) begin errors++; $display("FAIL busy_preamble_%0d: got %b expected 00000011", p, period_pat(t + 1 + 4 * p, 4)); end
        end
        checks++; if (pe_rise_q.size() != 1 || first_or_neg(pe_rise_q) != t + 17) begin errors++; $display("FAIL busy_preamble_end: got rise at +%0d expected +17", first_or_neg(pe_rise_q) - t); end
        checks++; if (done_q.size() != 1 || first_or_neg(done_q) != t + 49) begin errors++; $display("FAIL busy_done: got %0d pulses at +%0d expected 1 at +49", done_q.size(), first_or_neg(done_q) - t); end
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL busy_rx_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            a = rx_q.pop_front();
            x = exp_q.pop_front();
            checks++; if (a !== x) begin errors++; $display("FAIL busy_rx_byte: got %h expected %h", a, x); end
        end
        clear_sb();
        enable = 1'b0;
        start_frame(8'd4, 8'd1, t);
        wait_until(t + 8);
        checks++; if (busy !== 1'b0 || high_at.num() != 0) begin errors++; $display("FAIL disabled_start: got busy=%b high=%0d expected 0/0", busy, high_at.num()); end
        enable = 1'b1;
    endtask

    task automatic test_loopback();
        int t;
        int n;
        logic [7:0] a;
        logic [7:0] x;
        clear_sb();
        set_rx(16);
        for (int i = 0; i < 256; i++) src_q.push_back(8'($urandom_range(0, 255)));
        start_frame(8'd16, 8'd255, t);
        n = 0;
        while (done_q.size() == 0 && ur_q.size() == 0 && n < 34000) begin
            tick();
            n++;
        end
        checks++; if (n >= 34000) begin errors++; $display("FAIL loop_timeout: got no frame end after %0d cycles expected end by +32705", n); end
        repeat (3) tick();
        checks++; if (pe_rise_q.size() != 1 || first_or_neg(pe_rise_q) != t + 65) begin errors++; $display("FAIL loop_lock: got rise at +%0d expected +65", first_or_neg(pe_rise_q) - t); end
        checks++; if (done_q.size() != 1 || first_or_neg(done_q) != t + 32705) begin errors++; $display("FAIL loop_done: got %0d pulses at +%0d expected 1 at +32705", done_q.size(), first_or_neg(done_q) - t); end
        checks++; if (ur_q.size() != 0) begin errors++; $display("FAIL loop_underrun: got %0d expected 0", ur_q.size()); end
        checks++; if (src_q.size() != 1) begin errors++; $display("FAIL loop_overfetch: got %0d bytes left expected 1", src_q.size()); end
        checks++; if (shape_err != 0) begin errors++; $display("FAIL loop_shape: got %0d bad cycles expected 0", shape_err); end
        checks++; if (rx_q.size() != 255 || exp_q.size() != 255) begin errors++; $display("FAIL loop_rx_count: got rx=%0d sent=%0d expected 255/255", rx_q.size(), exp_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            a = rx_q.pop_front();
            x = exp_q.pop_front();
            checks++; if (a !== x) begin errors++; $display("FAIL loop_rx_byte: got %h expected %h", a, x); end
        end
        clear_sb();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_clamp_empty();
        test_underrun();
        test_enable_abort();
        test_start_ignored();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
